rca_serial_add_ctrl: RTL and testbench
======================================

Name: rca_serial_add_ctrl

Overview:
Sequencing stage wrapped around the 8-bit ripple-carry adder (rcA). It accepts a stream of operand byte pairs, least significant byte first, and drives the adder's A/B/Cin inputs. It chains the adder's carry-out across cycles so that NUM_BYTES-wide words are added one byte per beat. Sum bytes are registered and emitted on a valid/ready output stream, with the word carry-out reported on the last beat.

Parameters:
NUM_BYTES, 4, bytes per operand word; legal range 1..16.
IDX_W, 4, width of the byte index counter; must satisfy 2^IDX_W >= NUM_BYTES.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  operand byte pair is present.
in_ready  output  1  stage can accept a byte pair this cycle.
in_a  input  8  operand A byte.
in_b  input  8  operand B byte.
in_cin  input  1  word carry-in; sampled only on the first byte of a word.
add_a  output  8  to rcA r_A.
add_b  output  8  to rcA r_B.
add_cin  output  1  to rcA r_Cin.
add_sum  input  8  from rcA r_Sum.
add_cout  input  1  from rcA r_Cout.
out_valid  output  1  sum byte is present.
out_ready  input  1  downstream accepts the sum byte.
out_sum  output  8  registered sum byte.
out_last  output  1  this beat is the most significant byte of the word.
out_cout  output  1  word carry-out; meaningful only when out_last=1, otherwise 0.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - out_valid, out_sum, out_last, out_cout, the carry register and the byte index all go to 0.
  - FSM goes to FIRST.
  - Any partial word is discarded; no output beat survives reset.
- Accept condition: acc = in_valid & in_ready.
- in_ready = !out_valid | out_ready. This is a one-deep pipeline with pass-through on a same-cycle pop.
- Combinational adder drive:
  - add_a = in_a, add_b = in_b.
  - add_cin = in_cin in FIRST, carry_q in NEXT.
- On acc:
  - out_sum <= add_sum.
  - out_valid <= 1.
  - carry_q <= add_cout.
  - out_last <= (idx == NUM_BYTES-1).
  - out_cout <= add_cout if last, else 0.
- When out_valid & out_ready & !acc: out_valid <= 0. out_sum, out_last and out_cout hold their values (don't care).
- Latency: exactly 1 cycle from accepted byte to out_valid.
- Throughput: 1 byte per cycle while out_ready=1.
- FSM:
  - FIRST: on acc, if NUM_BYTES==1 stay in FIRST with idx=0; else go to NEXT with idx=1.
  - NEXT: on acc, if idx==NUM_BYTES-1 go to FIRST with idx=0; else idx+1.
  - Without acc, state, idx and carry_q hold.
- Wrap-around: after the last byte, the next word starts in FIRST. The stored carry is not propagated into the next word; in_cin is used instead.
- Backpressure: while out_valid=1 and out_ready=0:
  - in_ready=0.
  - out_sum, out_last and out_cout are held stable.
  - carry_q and idx are frozen.
- Simultaneous pop and push in one cycle: out_valid stays 1 and the new byte replaces the old one, with no bubble.
- in_a, in_b and in_cin are ignored when in_valid=0. The adder outputs are consumed only on acc.
- Arithmetic is unsigned modulo 2^(8*NUM_BYTES); the carry out of the top byte is out_cout.

Optional Feature:
Macro RCA_SIGNED_OVF_EN.
- Defined: adds output port out_ovf, width 1.
  - On the last byte's acc: out_ovf <= (in_a[7]==in_b[7]) & (add_sum[7]!=in_a[7]). This is two's-complement overflow of the full word.
  - Non-last beats drive 0; reset value is 0.
  - out_ovf is held under backpressure like out_sum.
- Not defined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
1. NUM_BYTES=2, out_ready=1, cin=0: push (FF,01) then (00,00) -> beats out_sum=00/last=0/cout=0, then out_sum=01/last=1/cout=0 (result 0x0100).
2. NUM_BYTES=2: push 0xFFFF + 0x0001 as (FF,01),(FF,00) -> beats 00, then 00 with last=1, cout=1; out_ovf=0 if the macro is defined.
3. NUM_BYTES=2, macro defined: push 0x7FFF + 0x0001 -> beats 00, then 80 with last=1, cout=0, ovf=1. Then push 0x0003 + 0x0001 with cin=1 -> beats 05, then 00 with cout=0; the previous word's carry does not leak.
4. Backpressure: out_ready=0 after the first accepted byte -> in_ready=0, and out_sum is held at its value for 5 cycles. Raise out_ready -> the next byte is accepted in the same cycle with no dropped or duplicated beat.
5. Reset mid-word: NUM_BYTES=4, accept 2 bytes (FF,01),(FF,00), then rst_n=0 for 1 cycle -> all outputs 0 and state FIRST. Next push (01,01) with cin=0 yields out_sum=02, last=0, meaning a fresh word with carry cleared.
6. Back-to-back streaming: 8 words of NUM_BYTES=4 with random operands and in_valid=1 continuously -> 32 beats on 32 consecutive cycles. The reassembled sums and couts match a 32-bit reference model.

Source files
------------

// File: rtl/rca_serial_add_ctrl.sv
// Byte-serial sequencer around an external 8-bit ripple-carry adder: chains carry across beats
// and emits registered sum bytes on a valid/ready stream. Define RCA_SIGNED_OVF_EN to add out_ovf.
module rca_serial_add_ctrl #(
  parameter int NUM_BYTES = 4,
  parameter int IDX_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_cin,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_last,
  output logic       out_cout
`ifdef RCA_SIGNED_OVF_EN
  ,
  output logic       out_ovf
`endif
);

  localparam int DATA_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic {FIRST, NEXT} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q;
  logic              acc;
  logic              is_last;

  logic              vld_p1;
  logic [DATA_W-1:0] sum_p1;
  logic              last_p1;
  logic              cout_p1;

`ifdef RCA_SIGNED_OVF_EN
  logic              ovf_p1;

  // Same-sign operands whose top sum bit differs from them means the word overflowed.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
`endif

  assign in_ready = !vld_p1 | out_ready;
  assign acc      = in_valid & in_ready;
  assign is_last  = (idx_q == LAST_IDX);

  assign add_a    = in_a;
  assign add_b    = in_b;
  assign add_cin  = (state_q == FIRST) ? in_cin : carry_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (acc) begin
      case (state_q)
        FIRST: begin
          if (NUM_BYTES == 1) begin
            state_d = FIRST;
            idx_d   = '0;
          end else begin
            state_d = NEXT;
            idx_d   = IDX_W'(1);
          end
        end
        NEXT: begin
          if (is_last) begin
            state_d = FIRST;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_d = FIRST;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Stage p0 -> p1: adder result captured on accept; a pop without a push empties the stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FIRST;
      idx_q   <= '0;
      carry_q <= 1'b0;
      vld_p1  <= 1'b0;
      sum_p1  <= '0;
      last_p1 <= 1'b0;
      cout_p1 <= 1'b0;
`ifdef RCA_SIGNED_OVF_EN
      ovf_p1  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (acc) begin
        vld_p1  <= 1'b1;
        sum_p1  <= add_sum;
        carry_q <= add_cout;
        last_p1 <= is_last;
        cout_p1 <= is_last & add_cout;
`ifdef RCA_SIGNED_OVF_EN
        ovf_p1  <= is_last & signed_ovf(in_a[DATA_W-1], in_b[DATA_W-1], add_sum[DATA_W-1]);
`endif
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_sum   = sum_p1;
  assign out_last  = last_p1;
  assign out_cout  = cout_p1;
`ifdef RCA_SIGNED_OVF_EN
  assign out_ovf   = ovf_p1;
`endif

endmodule

// File: tb/tb_rca_serial_add_ctrl.sv
// Scoreboard bench for rca_serial_add_ctrl: one 2-byte and one 4-byte instance, each with a
// behavioural 8-bit adder; word-level expectations are queued and checked as beats leave.
module tb_rca_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_a, in_b;
  logic       in_cin;
  logic       sel;  // 0: 2-byte instance, 1: 4-byte instance

  logic       iv2, ir2, ac2, aco2, ov2, ol2, oc2;
  logic [7:0] aa2, ab2, as2, os2;
  logic       iv4, ir4, ac4, aco4, ov4, ol4, oc4;
  logic [7:0] aa4, ab4, as4, os4;
`ifdef RCA_SIGNED_OVF_EN
  logic       oo2, oo4, cur_ovf;
`endif

  assign iv2 = in_valid & !sel;
  assign iv4 = in_valid & sel;
  assign {aco2, as2} = {1'b0, aa2} + {1'b0, ab2} + {8'b0, ac2};
  assign {aco4, as4} = {1'b0, aa4} + {1'b0, ab4} + {8'b0, ac4};

  rca_serial_add_ctrl #(.NUM_BYTES(2), .IDX_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .add_a(aa2), .add_b(ab2), .add_cin(ac2), .add_sum(as2), .add_cout(aco2),
    .out_valid(ov2), .out_ready(out_ready), .out_sum(os2), .out_last(ol2), .out_cout(oc2)
`ifdef RCA_SIGNED_OVF_EN
    , .out_ovf(oo2)
`endif
  );

  rca_serial_add_ctrl #(.NUM_BYTES(4), .IDX_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .add_a(aa4), .add_b(ab4), .add_cin(ac4), .add_sum(as4), .add_cout(aco4),
    .out_valid(ov4), .out_ready(out_ready), .out_sum(os4), .out_last(ol4), .out_cout(oc4)
`ifdef RCA_SIGNED_OVF_EN
    , .out_ovf(oo4)
`endif
  );

  logic       cur_ready, cur_valid, cur_last, cur_cout;
  logic [7:0] cur_sum;
  assign cur_ready = sel ? ir4 : ir2;
  assign cur_valid = sel ? ov4 : ov2;
  assign cur_sum   = sel ? os4 : os2;
  assign cur_last  = sel ? ol4 : ol2;
  assign cur_cout  = sel ? oc4 : oc2;
`ifdef RCA_SIGNED_OVF_EN
  assign cur_ovf   = sel ? oo4 : oo2;
`endif

  typedef struct packed {
    logic [7:0] sum;
    logic       last;
    logic       cout;
    logic       ovf;
  } beat_t;

  beat_t exp_q[$];
  beat_t e_mon;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int beat_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: a beat transfers at the next rising edge when valid & ready hold at the falling edge.
  always @(negedge clk) begin
    if (cur_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got sum=%h last=%b cout=%b, required no beat",
                 cur_sum, cur_last, cur_cout);
      end else begin
        e_mon = exp_q.pop_front();
        if ({cur_sum, cur_last, cur_cout} !== {e_mon.sum, e_mon.last, e_mon.cout}) begin
          n_fail++;
          $display("FAIL beat: got sum=%h last=%b cout=%b, required sum=%h last=%b cout=%b",
                   cur_sum, cur_last, cur_cout, e_mon.sum, e_mon.last, e_mon.cout);
        end
`ifdef RCA_SIGNED_OVF_EN
        n_cmp++;
        if (cur_ovf !== e_mon.ovf) begin
          n_fail++;
          $display("FAIL beat_ovf: got %b, required %b", cur_ovf, e_mon.ovf);
        end
`endif
      end
      beat_cnt++;
      if (beat_cnt == 1) first_cyc = cyc;
      last_cyc = cyc;
    end
  end

  task automatic expect_word(input logic [31:0] a, input logic [31:0] b, input logic cin,
                             input int nb);
    logic [32:0] s;
    beat_t e;
    s = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    for (int i = 0; i < nb; i++) begin
      e.sum  = s[8*i +: 8];
      e.last = (i == nb - 1);
      e.cout = e.last ? s[8*nb] : 1'b0;
      e.ovf  = e.last ? ((a[8*nb-1] == b[8*nb-1]) && (s[8*nb-1] != a[8*nb-1])) : 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_byte(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int k;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (cur_ready !== 1'b1 && k < 50) begin
      k++;
      @(negedge clk);
    end
    if (cur_ready !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b, required 1", cur_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] b, input logic cin,
                           input int nb);
    expect_word(a, b, cin, nb);
    for (int i = 0; i < nb; i++) push_byte(a[8*i +: 8], b[8*i +: 8], cin);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (cur_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: out_valid=%b, required 0", name, cur_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_a = 8'h00;
    in_b = 8'h00;
    in_cin = 1'b0;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({ov2, os2, ol2, oc2, ir2} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_dut2: got v=%b s=%h l=%b c=%b r=%b, required 0 00 0 0 1",
               ov2, os2, ol2, oc2, ir2);
    end
    n_cmp++;
    if ({ov4, os4, ol4, oc4, ir4} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_dut4: got v=%b s=%h l=%b c=%b r=%b, required 0 00 0 0 1",
               ov4, os4, ol4, oc4, ir4);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_words;
    sel = 1'b0;
    out_ready = 1'b1;
    push_word(32'h00FF, 32'h0001, 1'b0, 2);  // 0x0100
    push_word(32'hFFFF, 32'h0001, 1'b0, 2);  // 0x10000, cout=1
    push_word(32'h7FFF, 32'h0001, 1'b0, 2);  // 0x8000, signed overflow
    push_word(32'h0003, 32'h0001, 1'b1, 2);  // 0x0005, fresh carry-in
    in_valid = 1'b0;
    wait_drain("basic");
  endtask

  task automatic test_backpressure;
    sel = 1'b0;
    out_ready = 1'b0;
    expect_word(32'h1234, 32'h0101, 1'b0, 2);
    push_byte(8'h34, 8'h01, 1'b0);
    in_a = 8'h12;
    in_b = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({cur_ready, cur_valid, cur_sum, cur_last} !== {1'b0, 1'b1, 8'h35, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%b s=%h l=%b, required 0 1 35 0",
                 i, cur_ready, cur_valid, cur_sum, cur_last);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cur_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b, required 1", cur_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain("bp");
  endtask

  task automatic test_reset_mid_word;
    beat_t e;
    sel = 1'b1;
    out_ready = 1'b1;
    e = '{sum: 8'h00, last: 1'b0, cout: 1'b0, ovf: 1'b0};
    exp_q.push_back(e);
    exp_q.push_back(e);
    push_byte(8'hFF, 8'h01, 1'b0);
    push_byte(8'hFF, 8'h00, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ov4, os4, ol4, oc4, ir4} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset_out: got v=%b s=%h l=%b c=%b r=%b, required 0 00 0 0 1",
               ov4, os4, ol4, oc4, ir4);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_beats: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    push_word(32'h0000_0001, 32'h0000_0001, 1'b0, 4);
    in_valid = 1'b0;
    wait_drain("midreset");
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    logic        c;
    sel = 1'b1;
    out_ready = 1'b1;
    beat_cnt = 0;
    for (int w = 0; w < 8; w++) begin
      a = $urandom();
      b = $urandom();
      c = 1'($urandom_range(0, 1));
      if (w == 0) begin
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0001;
      end
      push_word(a, b, c, 4);
    end
    in_valid = 1'b0;
    wait_drain("b2b");
    n_cmp++;
    if (beat_cnt != 32 || (last_cyc - first_cyc) != 31) begin
      n_fail++;
      $display("FAIL b2b_rate: got %0d beats over %0d cycles, required 32 over 31",
               beat_cnt, last_cyc - first_cyc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_words();
    test_backpressure();
    test_reset_mid_word();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
